// File: rtl/fp_iter_seq_ctrl.sv
// Sequencing controller for the iterative single-precision add/sub datapath.
// Walks one operand pair through ALIGN/ADD/NORM/ROUND (or EXC) and hands the result off.
module fp_iter_seq_ctrl #(
   parameter int SHIFT_STEP = 4,
   parameter int SHIFT_SAT  = 26,
   parameter int NORM_MAX   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       exp_a_ge_b,
   input  logic [9:0] shift_det,
   input  logic [4:0] input_exc,
   input  logic       op_in,
   input  logic       norm_done,
   input  logic       out_ready,
   output logic       out_valid,
   output logic       pre_ld,
   output logic       swap,
   output logic       align_en,
   output logic [4:0] align_amt,
   output logic       add_en,
   output logic       sub_sel,
   output logic       norm_en,
   output logic       round_en,
   output logic       exc_sel,
   output logic       busy
);

   localparam int NCW = $clog2(NORM_MAX + 1);
   localparam logic [4:0]     STEP5 = 5'(SHIFT_STEP);
   localparam logic [4:0]     SAT5  = 5'(SHIFT_SAT);
   localparam logic [NCW-1:0] NMAX  = NCW'(NORM_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_EXC,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic           swap_q, swap_d;
   logic           sub_q, sub_d;
   logic           exc_q, exc_d;
   logic [4:0]     rem_q, rem_d;
   logic [NCW-1:0] ncnt_q, ncnt_d;

   logic [4:0] shift_sel;
   logic [4:0] shift_sat;
   logic [4:0] step_amt;

   // Only the summary "any exception" bit steers sequencing; the rest feed the datapath mux.
   logic unused_exc_bits;
   assign unused_exc_bits = ^input_exc[3:0];

   always_comb begin
      shift_sel = exp_a_ge_b ? shift_det[4:0] : shift_det[9:5];
      shift_sat = (shift_sel > SAT5) ? SAT5 : shift_sel;
      step_amt  = (rem_q > STEP5) ? STEP5 : rem_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         swap_q  <= 1'b0;
         sub_q   <= 1'b0;
         exc_q   <= 1'b0;
         rem_q   <= '0;
         ncnt_q  <= '0;
      end else begin
         state_q <= state_d;
         swap_q  <= swap_d;
         sub_q   <= sub_d;
         exc_q   <= exc_d;
         rem_q   <= rem_d;
         ncnt_q  <= ncnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      swap_d    = swap_q;
      sub_d     = sub_q;
      exc_d     = exc_q;
      rem_d     = rem_q;
      ncnt_d    = ncnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      pre_ld    = 1'b0;
      align_en  = 1'b0;
      align_amt = 5'd0;
      add_en    = 1'b0;
      norm_en   = 1'b0;
      round_en  = 1'b0;
      exc_sel   = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pre_ld = 1'b1;
               swap_d = ~exp_a_ge_b;
               sub_d  = op_in;
               exc_d  = input_exc[4];
               rem_d  = shift_sat;
               ncnt_d = '0;
               if (input_exc[4]) begin
                  state_d = S_EXC;
               end else if (shift_sat != 5'd0) begin
                  state_d = S_ALIGN;
               end else begin
                  state_d = S_ADD;
               end
            end
         end
         S_ALIGN: begin
            align_en  = 1'b1;
            align_amt = step_amt;
            rem_d     = rem_q - step_amt;
            if (rem_d == 5'd0) begin
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            add_en  = 1'b1;
            state_d = S_NORM;
         end
         S_NORM: begin
            // An already-normalized mantissa costs no shift; otherwise step until the timeout.
            if (norm_done) begin
               state_d = S_ROUND;
            end else begin
               norm_en = 1'b1;
               ncnt_d  = ncnt_q + NCW'(1);
               if (ncnt_d == NMAX) begin
                  state_d = S_ROUND;
               end
            end
         end
         S_ROUND: begin
            round_en = 1'b1;
            state_d  = S_DONE;
         end
         S_EXC: begin
            exc_sel = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            exc_sel   = exc_q;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign swap    = swap_q;
   assign sub_sel = sub_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_iter_seq_ctrl.sv
// Scoreboard bench for fp_iter_seq_ctrl: directed transactions push expected
// sequencing summaries, a negedge monitor measures the DUT and compares at handoff.
module tb_fp_iter_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       exp_a_ge_b;
   logic [9:0] shift_det;
   logic [4:0] input_exc;
   logic       op_in;
   logic       norm_done;
   logic       out_ready;
   logic       out_valid;
   logic       pre_ld;
   logic       swap;
   logic       align_en;
   logic [4:0] align_amt;
   logic       add_en;
   logic       sub_sel;
   logic       norm_en;
   logic       round_en;
   logic       exc_sel;
   logic       busy;

   fp_iter_seq_ctrl #(.SHIFT_STEP(4), .SHIFT_SAT(26), .NORM_MAX(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .exp_a_ge_b(exp_a_ge_b), .shift_det(shift_det), .input_exc(input_exc),
      .op_in(op_in), .norm_done(norm_done),
      .out_ready(out_ready), .out_valid(out_valid),
      .pre_ld(pre_ld), .swap(swap), .align_en(align_en), .align_amt(align_amt),
      .add_en(add_en), .sub_sel(sub_sel), .norm_en(norm_en), .round_en(round_en),
      .exc_sel(exc_sel), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int exc;
      int swp;
      int sub;
      int lat;
      int n_align;
      int amt_sum;
      int last_amt;
      int n_add;
      int n_norm;
      int n_round;
   } exp_t;

   exp_t sb_q[$];
   int total = 0;
   int bad = 0;
   int n_pushed = 0;
   int n_popped = 0;

   task automatic check(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   function automatic exp_t mk(input int exc, input int swp, input int sub, input int lat,
                               input int n_align, input int amt_sum, input int last_amt,
                               input int n_add, input int n_norm, input int n_round);
      exp_t e;
      e.exc = exc; e.swp = swp; e.sub = sub; e.lat = lat;
      e.n_align = n_align; e.amt_sum = amt_sum; e.last_amt = last_amt;
      e.n_add = n_add; e.n_norm = n_norm; e.n_round = n_round;
      return e;
   endfunction

   // Monitor: measures each operation from its pre_ld cycle to the output handoff.
   initial begin
      bit active = 0;
      bit seen_v = 0;
      bit ready_chk = 0;
      int cyc = 0, n_al = 0, sum = 0, last = 0, n_ad = 0, n_no = 0, n_ro = 0;
      int v_exc = 0, v_swp = 0, v_sub = 0, lat = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 0;
            seen_v = 0;
            ready_chk = 0;
         end else begin
            if (ready_chk) begin
               check("ready_after_handoff", int'(in_ready), 1);
               check("valid_drop_after_handoff", int'(out_valid), 0);
               ready_chk = 0;
            end
            check("enable_onehot", int'($countones({align_en, add_en, norm_en, round_en, pre_ld}) <= 1), 1);
            if (pre_ld) check("pre_ld_only_when_ready", int'(in_ready), 1);
            if (pre_ld) begin
               active = 1; seen_v = 0; cyc = 0;
               n_al = 0; sum = 0; last = 0; n_ad = 0; n_no = 0; n_ro = 0;
            end else if (active) begin
               cyc++;
               if (align_en) begin n_al++; sum += int'(align_amt); last = int'(align_amt); end
               if (add_en) n_ad++;
               if (norm_en) n_no++;
               if (round_en) n_ro++;
            end
            if (out_valid) begin
               if (!active) begin
                  check("spurious_out_valid", 1, 0);
               end else if (!seen_v) begin
                  seen_v = 1; lat = cyc;
                  v_exc = int'(exc_sel); v_swp = int'(swap); v_sub = int'(sub_sel);
               end else begin
                  check("done_exc_sel_stable", int'(exc_sel), v_exc);
                  check("done_swap_stable", int'(swap), v_swp);
                  check("done_in_ready_low", int'(in_ready), 0);
               end
               if (out_ready && active) begin
                  if (sb_q.size() == 0) begin
                     check("scoreboard_empty", 1, 0);
                  end else begin
                     e = sb_q.pop_front();
                     n_popped++;
                     check("latency", lat, e.lat);
                     check("exc_sel", v_exc, e.exc);
                     check("swap", v_swp, e.swp);
                     check("sub_sel", v_sub, e.sub);
                     check("align_cycles", n_al, e.n_align);
                     check("align_sum", sum, e.amt_sum);
                     check("align_last", last, e.last_amt);
                     check("add_pulses", n_ad, e.n_add);
                     check("norm_pulses", n_no, e.n_norm);
                     check("round_pulses", n_ro, e.n_round);
                     $display("txn %0d: lat=%0d exc=%0d swap=%0d sub=%0d align=%0d/%0d last=%0d add=%0d norm=%0d round=%0d",
                              n_popped, lat, v_exc, v_swp, v_sub, n_al, sum, last, n_ad, n_no, n_ro);
                  end
                  active = 0;
                  ready_chk = 1;
               end
            end
         end
      end
   end

   task automatic run_txn(input bit ge, input logic [9:0] sd, input logic [4:0] exc, input bit op,
                          input bit nd, input int hold, input exp_t e);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("wait_in_ready", int'(in_ready), 1);
      exp_a_ge_b = ge; shift_det = sd; input_exc = exc; op_in = op;
      norm_done = nd; out_ready = 1'b0; in_valid = 1'b1;
      sb_q.push_back(e);
      n_pushed++;
      @(posedge clk); #1;
      // Scramble the pair inputs so the bench notices anything not latched at accept.
      in_valid = 1'b0; shift_det = 10'h3ff; exp_a_ge_b = ~ge; op_in = ~op; input_exc = 5'b0;
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!out_valid) begin
         check("out_valid_timeout", 0, 1);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; input_exc = 5'b0; shift_det = 10'd0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string nm);
      check(nm, int'({in_ready, out_valid, pre_ld, swap, align_en, align_amt, add_en,
                      sub_sel, norm_en, round_en, exc_sel, busy}), 16'h8000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; exp_a_ge_b = 1'b0; shift_det = 10'd0;
      input_exc = 5'd0; op_in = 1'b0; norm_done = 1'b1; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_outputs");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // shift 10 via DAB: 4,4,2 then add, norm done at once, round
      run_txn(1'b1, {5'd0, 5'd10}, 5'b0, 1'b0, 1'b1, 0, mk(0, 0, 0, 7, 3, 10, 2, 1, 0, 1));
      // DBA=31 saturates to 26: seven align cycles, last one 2
      run_txn(1'b0, {5'd31, 5'd1}, 5'b0, 1'b1, 1'b1, 0, mk(0, 1, 1, 11, 7, 26, 2, 1, 0, 1));
      // A NaN: exception bypass, held 5 cycles in DONE with in_valid pulsing
      run_txn(1'b1, {5'd0, 5'd5}, 5'b11000, 1'b0, 1'b1, 5, mk(1, 0, 0, 2, 0, 0, 0, 0, 0, 0));
      // no align, norm never done: NORM_MAX norm pulses
      run_txn(1'b1, 10'd0, 5'b0, 1'b0, 1'b0, 0, mk(0, 0, 0, 11, 0, 0, 0, 1, 8, 1));
      // unselected DBA field nonzero still skips align
      run_txn(1'b1, {5'd3, 5'd0}, 5'b0, 1'b1, 1'b1, 0, mk(0, 0, 1, 4, 0, 0, 0, 1, 0, 1));
      // DBA=20: five full steps
      run_txn(1'b0, {5'd20, 5'd0}, 5'b0, 1'b0, 1'b1, 0, mk(0, 1, 0, 9, 5, 20, 4, 1, 0, 1));

      // Abort a 7-cycle align in its third cycle
      exp_a_ge_b = 1'b1; shift_det = {5'd0, 5'd26}; op_in = 1'b1; norm_done = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("align_before_reset", int'(align_en), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_align");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("idle_after_abort", int'({in_ready, busy}), 2);

      // recovery after abort
      run_txn(1'b0, {5'd2, 5'd9}, 5'b0, 1'b0, 1'b1, 0, mk(0, 1, 0, 5, 1, 2, 2, 1, 0, 1));

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      check("txn_count", n_popped, n_pushed);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_iter_seq_ctrl.md
Name: fp_iter_seq_ctrl

Overview:
Sequencing controller for the iterative single-precision add/subtract datapath built around one shared DSP48E1. It accepts one operand pair at a time through a valid/ready handshake and latches the prealign results: signs, exception vector and shift data. It then steps the datapath through ALIGN, ADD, NORM and ROUND using per-stage enables, and presents the result under an output valid/ready handshake. Exception inputs bypass the arithmetic stages.

Parameters:
SHIFT_STEP, 4, alignment shift bits applied per ALIGN cycle (power of 2, 1..16)
SHIFT_SAT, 26, alignment shift saturation; larger exponent differences flush the smaller operand
NORM_MAX, 8, NORM-cycle timeout before forcing round

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair and prealign outputs valid
in_ready  out  1  controller can accept a new pair
exp_a_ge_b  in  1  ExpA >= ExpB, from the datapath comparator
shift_det  in  10  {DBA[4:0], DAB[4:0]} from prealign
input_exc  in  5  {any, ANaN, BNaN, AInf, BInf} from prealign
op_in  in  1  0 = add, 1 = subtract
norm_done  in  1  datapath mantissa normalized (MSB set or result zero)
out_ready  in  1  downstream accepts result
out_valid  out  1  result valid
pre_ld  out  1  load operand and prealign registers
swap  out  1  route B as the larger operand (latched ~exp_a_ge_b)
align_en  out  1  shift smaller mantissa right by align_amt this cycle
align_amt  out  5  shift amount this cycle, 0..SHIFT_STEP
add_en  out  1  DSP48E1 add/sub cycle
sub_sel  out  1  DSP ALUMODE select (latched op_in)
norm_en  out  1  normalize step
round_en  out  1  round and pack
exc_sel  out  1  output mux selects exception result
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except in_ready = 1. Internal counters cleared. Reset mid-operation aborts and discards the operation with no out_valid pulse.
- States:
  - IDLE: in_ready = 1. When in_valid, accept in the same cycle with pre_ld = 1 and latch swap, sub_sel, input_exc[4] and shift amount. Shift amount = exp_a_ge_b ? shift_det[4:0] : shift_det[9:5], saturated to SHIFT_SAT. Go to EXC if input_exc[4], else ALIGN if shift amount > 0, else ADD.
  - ALIGN: align_en = 1; align_amt = min(remaining, SHIFT_STEP); remaining -= align_amt. Go to ADD in the cycle after the last nonzero step. Cycle count = ceil(shift/SHIFT_STEP); for example, shift 26 with step 4 takes 7 cycles.
  - ADD: exactly 1 cycle with add_en = 1, then NORM.
  - NORM: if norm_done is sampled high, go to ROUND with no norm_en that cycle. Otherwise norm_en = 1 and the norm counter increments. When the counter reaches NORM_MAX, go to ROUND regardless.
  - ROUND: 1 cycle with round_en = 1, then DONE.
  - EXC: 1 cycle with exc_sel = 1, then DONE. exc_sel stays 1 through DONE.
  - DONE: out_valid = 1, held with stable outputs until out_ready. When out_ready, go to IDLE; in_ready rises the next cycle, so there is no same-cycle pass-through.
- in_ready is 1 only in IDLE. in_valid is ignored in all other states.
- busy = (state != IDLE).
- Latency with no alignment and an already-normalized sum: IDLE accept -> ADD -> NORM -> ROUND -> DONE. out_valid asserts 4 cycles after the accept edge.
- Exception path: accept -> EXC -> DONE, so out_valid asserts 2 cycles after accept.
- Control enables (align_en, add_en, norm_en, round_en, pre_ld) are mutually exclusive and one-hot per cycle.
- Shift amount 0 skips ALIGN entirely.
- The 5-bit shift field wraps modulo 32. Saturation applies to the selected 5-bit field only.

Test Plan:
- Reset mid-ALIGN (rst_n low at cycle 3 of a 7-cycle align) -> IDLE immediately, all enables 0, in_ready = 1, no out_valid.
- exp_a_ge_b = 1, shift_det = {5'd0, 5'd10}, norm_done = 1 -> swap = 0; align_amt sequence 4, 4, 2; 1 add_en; round_en; out_valid at accept + 7.
- exp_a_ge_b = 0, shift_det = {5'd31, 5'd1} -> swap = 1; shift saturates to 26; 7 align cycles with the last align_amt = 2.
- input_exc = 5'b11000 (A NaN) -> no align_en/add_en; exc_sel = 1; out_valid at accept + 2.
- shift 0, norm_done held low -> exactly NORM_MAX (8) norm_en pulses, then round_en, then out_valid.
- out_ready held low for 5 cycles in DONE -> out_valid and exc_sel stable. in_valid asserted meanwhile is not accepted. in_ready rises the cycle after out_ready.
